// File: rtl/result_capture.sv
// Sink for the adder result stream: buffers {overflow, sum} beats in a small FIFO,
// drains them over valid/ready and keeps saturating drop / overflow statistics.
module result_capture #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_sum,
  input  logic                       i_overflow,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_data_ovf,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_WIDTH-1:0]       o_drop_count,
  output logic [CNT_WIDTH-1:0]       o_ovf_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [LvlW-1:0]  lvl_t;
  typedef logic [WIDTH:0]   entry_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  lvl_t   level_q, level_d;
  cnt_t   drop_cnt_q, drop_cnt_d;
  cnt_t   ovf_cnt_q, ovf_cnt_d;

  logic full, empty, pop, push, drop;

  assign full  = (level_q == lvl_t'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && i_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push  = i_valid && (!full || pop);
  assign drop  = i_valid && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {i_overflow, i_sum};
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + cnt_t'(1);
    end
    if (push && i_overflow && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + cnt_t'(1);
    end
  end

  // Storage is cleared too so the head outputs read 0 out of reset instead of X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_comb begin
    o_valid      = !empty;
    o_data       = mem_q[rd_ptr_q][WIDTH-1:0];
    o_data_ovf   = mem_q[rd_ptr_q][WIDTH];
    o_level      = level_q;
    o_full       = full;
    o_empty      = empty;
    o_drop_count = drop_cnt_q;
    o_ovf_count  = ovf_cnt_q;
  end

endmodule

// File: tb/tb_result_capture.sv
// Randomised and directed bench for result_capture, checked against a queue-based
// model of the FIFO and its saturating statistics.
module tb_result_capture;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned MAX_CNT   = (1 << CNT_WIDTH) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_sum;
  logic                   in_ovf;
  logic                   out_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_data_ovf;
  logic [$clog2(DEPTH):0] out_level;
  logic                   out_full;
  logic                   out_empty;
  logic [CNT_WIDTH-1:0]   out_drop;
  logic [CNT_WIDTH-1:0]   out_ovfc;

  int n_vec;
  int n_err;

  // Reference model: queue of {ovf, sum} plus two plain integer counters.
  logic [WIDTH:0] mq[$];
  int unsigned    m_drop;
  int unsigned    m_ovf;

  result_capture #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (in_valid),
    .i_sum       (in_sum),
    .i_overflow  (in_ovf),
    .o_valid     (out_valid),
    .i_ready     (in_ready),
    .o_data      (out_data),
    .o_data_ovf  (out_data_ovf),
    .o_level     (out_level),
    .o_full      (out_full),
    .o_empty     (out_empty),
    .o_drop_count(out_drop),
    .o_ovf_count (out_ovfc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(out_empty), 64'd1);
    check("rst_full",  64'(out_full),  64'd0);
    check("rst_level", 64'(out_level), 64'd0);
    check("rst_drop",  64'(out_drop),  64'd0);
    check("rst_ovfc",  64'(out_ovfc),  64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_dovf",  64'(out_data_ovf), 64'd0);
  endtask

  task automatic compare_all();
    logic [WIDTH:0] head;
    check("level", 64'(out_level), 64'(mq.size()));
    check("valid", 64'(out_valid), 64'(mq.size() != 0));
    check("empty", 64'(out_empty), 64'(mq.size() == 0));
    check("full",  64'(out_full),  64'(mq.size() == DEPTH));
    check("drop",  64'(out_drop),  64'(m_drop));
    check("ovfc",  64'(out_ovfc),  64'(m_ovf));
    if (mq.size() != 0) begin
      head = mq[0];
      check("data", 64'(out_data),     64'(head[WIDTH-1:0]));
      check("dovf", 64'(out_data_ovf), 64'(head[WIDTH]));
    end
  endtask

  // One clock cycle of stimulus; model decisions use the state before the edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] s, input logic ovf,
                      input logic rdy);
    bit pop, full, push, drop;
    @(negedge clk);
    in_valid = v;
    in_sum   = s;
    in_ovf   = ovf;
    in_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    push = v && (!full || pop);
    drop = v && full && !pop;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({ovf, s});
    if (drop && m_drop < MAX_CNT) m_drop++;
    if (push && ovf && m_ovf < MAX_CNT) m_ovf++;
    #1;
    compare_all();
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    mq.delete();
    m_drop = 0;
    m_ovf  = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_ready = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    m_drop   = 0;
    m_ovf    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    in_ovf   = 1'b0;
    in_ready = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Buffer three beats, then drain them.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b0, 1'b0);
    check("tp1_data", 64'(out_data), 64'h10);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    check("tp1_empty", 64'(out_empty), 64'd1);

    // Overfill: three drops, first four retained.
    mid_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 32'(32'h100 + i), 1'b0, 1'b0);
    check("tp2_drop", 64'(out_drop), 64'd3);
    check("tp2_head", 64'(out_data), 64'h100);

    // Full with simultaneous push and pop: no drops, level holds.
    for (int i = 0; i < 10; i++) step(1'b1, 32'(32'h200 + i), 1'b0, 1'b1);
    check("tp3_level", 64'(out_level), 64'd4);
    check("tp3_drop",  64'(out_drop),  64'd3);

    // Overflow statistics; a dropped overflow beat is not counted.
    mid_reset();
    begin
      logic [4:0] pat;
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) step(1'b1, 32'(i), pat[i], 1'b1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("tp4_ovf3", 64'(out_ovfc), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h300 + i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b1, 1'b0);
    check("tp4_ovf_keep", 64'(out_ovfc), 64'd3);

    // Drop counter saturation.
    for (int i = 0; i < int'(MAX_CNT) + 6; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    check("tp5_sat", 64'(out_drop), 64'(MAX_CNT));

    // Asynchronous reset with two entries buffered, then a fresh beat.
    mid_reset();
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 32'hAB, 1'b0, 1'b0);
    check("tp6_head", 64'(out_data), 64'hAB);

    // Random traffic, including overflow saturation.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
